// File: rtl/row_window_reader_pkg.sv
// ----------------------------------------------------------------------------
// row_window_reader_pkg
//   Shared definitions for the row window reader. The write control codes are
//   the ones the row register bank decodes.
//   Also holds the window FSM state type and slot arithmetic helpers.
// ----------------------------------------------------------------------------
package row_window_reader_pkg;

   // Write control codes broadcast to the row bank
   localparam logic [2:0] CTRL_NONE = 3'd0;
   localparam logic [2:0] CTRL_ROW1 = 3'd1;
   localparam logic [2:0] CTRL_ROW2 = 3'd2;
   localparam logic [2:0] CTRL_ROW3 = 3'd3;
   localparam logic [2:0] CTRL_ROW4 = 3'd4;

   // Window presentation FSM states
   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_LOAD    = 2'd1,
      S_PRESENT = 2'd2
   } win_state_t;

   // True when the control code writes one of the four bank slots
   function automatic logic is_row_write(input logic [2:0] ctrl);
      return (ctrl >= CTRL_ROW1) && (ctrl <= CTRL_ROW4);
   endfunction

   // 0-based index of the slot that lies 'back' positions before the 1-based
   // slot 'newest', wrapping modulo 4 (slot 4 has low bits 2'b00, so the
   // 2-bit subtraction wraps it onto index 3).
   function automatic logic [1:0] slot_back(input logic [2:0] newest,
                                            input logic [1:0] back);
      logic [1:0] base;
      base = newest[1:0] - 2'd1;
      return base - back;
   endfunction

endpackage

// File: rtl/row_window_reader_tracker.sv
// ----------------------------------------------------------------------------
// row_slot_tracker
//   Snoops the row bank write control and tracks the frame fill level and the
//   row count within the frame. It flags write events that complete a
//   three-row window and marks the window holding the last row of a frame.
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset
//   control       in   row bank write control (1..4 = slot written)
//   window_event  out  this cycle's write completes a window
//   window_last   out  that window holds row IMG_ROWS-1 of the frame
// ----------------------------------------------------------------------------
module row_slot_tracker
   import row_window_reader_pkg::*;
#(
   parameter int IMG_ROWS = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] control,
   output logic       window_event,
   output logic       window_last
);

   localparam int CNT_W = $clog2(IMG_ROWS + 1);

   logic [2:0]       newest_r;
   logic [2:0]       fill_cnt_r;
   logic [CNT_W-1:0] row_cnt_r;

   logic             write_s;
   logic [2:0]       fill_inc_s;
   logic [CNT_W-1:0] row_inc_s;
   logic             last_s;

   assign write_s      = is_row_write(control);
   assign fill_inc_s   = (fill_cnt_r == 3'd4) ? 3'd4 : (fill_cnt_r + 3'd1);
   assign row_inc_s    = row_cnt_r + CNT_W'(1);
   assign last_s       = (row_inc_s == CNT_W'(IMG_ROWS));
   assign window_event = write_s && (fill_inc_s >= 3'd3);
   assign window_last  = last_s;

   // Newest slot, fill level and frame row count; both counts restart after
   // the last row so the next frame needs three fresh rows before a window.
   // The newest slot survives the frame boundary because the bank keeps
   // rotating through its slots.
   always_ff @(posedge clock) begin
      if (reset) begin
         newest_r   <= CTRL_NONE;
         fill_cnt_r <= 3'd0;
         row_cnt_r  <= '0;
      end else if (write_s) begin
         newest_r <= control;
         if (last_s) begin
            fill_cnt_r <= 3'd0;
            row_cnt_r  <= '0;
         end else begin
            fill_cnt_r <= fill_inc_s;
            row_cnt_r  <= row_inc_s;
         end
      end else begin
         newest_r   <= newest_r;
         fill_cnt_r <= fill_cnt_r;
         row_cnt_r  <= row_cnt_r;
      end
   end

endmodule

// File: rtl/row_window_reader.sv
// ----------------------------------------------------------------------------
// row_window_reader
//   Presents the three most recent rows of the four-slot row bank (oldest
//   first) as one window over a valid/ready handshake.
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   control                 row bank write control being snooped
//   row_addr_1..row_addr_4  row bank slot contents
//   win_valid / win_ready   window handshake
//   win_top/win_mid/win_bot window rows, oldest to newest
//   win_last                window contains the frame's last row
//   frame_done              one-cycle pulse after the last window is accepted
//   overrun                 sticky: a pending window was replaced before use
// ----------------------------------------------------------------------------
module row_window_reader
   import row_window_reader_pkg::*;
#(
   parameter int ROW_W    = 2304,
   parameter int IMG_ROWS = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [2:0]       control,
   input  logic [ROW_W-1:0] row_addr_1,
   input  logic [ROW_W-1:0] row_addr_2,
   input  logic [ROW_W-1:0] row_addr_3,
   input  logic [ROW_W-1:0] row_addr_4,
   output logic             win_valid,
   input  logic             win_ready,
   output logic [ROW_W-1:0] win_top,
   output logic [ROW_W-1:0] win_mid,
   output logic [ROW_W-1:0] win_bot,
   output logic             win_last,
   output logic             frame_done,
   output logic             overrun
);

   win_state_t       state_r, state_nxt_s;
   logic             pend_r, pend_nxt_s;
   logic             overrun_r, overrun_nxt_s;
   logic             load_en_s;
   logic             accept_s;

   logic             window_evt_s;
   logic             window_last_s;

   logic [2:0]       cap_slot_r;
   logic             cap_last_r;

   logic [ROW_W-1:0] slot_rows_s [4];
   logic [ROW_W-1:0] top_sel_s, mid_sel_s, bot_sel_s;

   logic             win_valid_r;
   logic [ROW_W-1:0] win_top_r, win_mid_r, win_bot_r;
   logic             win_last_r;
   logic             frame_done_r;

   row_slot_tracker #(
      .IMG_ROWS (IMG_ROWS)
   ) u_tracker (
      .clock        (clock),
      .reset        (reset),
      .control      (control),
      .window_event (window_evt_s),
      .window_last  (window_last_s)
   );

   assign slot_rows_s[0] = row_addr_1;
   assign slot_rows_s[1] = row_addr_2;
   assign slot_rows_s[2] = row_addr_3;
   assign slot_rows_s[3] = row_addr_4;

   // The load reads slots relative to the newest window event captured here,
   // so a later frame-start write cannot redirect a pending window.
   assign top_sel_s = slot_rows_s[slot_back(cap_slot_r, 2'd2)];
   assign mid_sel_s = slot_rows_s[slot_back(cap_slot_r, 2'd1)];
   assign bot_sel_s = slot_rows_s[slot_back(cap_slot_r, 2'd0)];

   assign accept_s  = (state_r == S_PRESENT) && win_ready;

   // Capture slot and last-row flag of the most recent window-producing write
   always_ff @(posedge clock) begin
      if (reset) begin
         cap_slot_r <= CTRL_NONE;
         cap_last_r <= 1'b0;
      end else if (window_evt_s) begin
         cap_slot_r <= control;
         cap_last_r <= window_last_s;
      end else begin
         cap_slot_r <= cap_slot_r;
         cap_last_r <= cap_last_r;
      end
   end

   // Next-state logic: at most one window waits behind the presented one;
   // a further window replaces it and raises overrun. Loading always reads
   // the newest captured window.
   always_comb begin
      state_nxt_s   = state_r;
      pend_nxt_s    = pend_r;
      overrun_nxt_s = overrun_r;
      load_en_s     = 1'b0;
      case (state_r)
         S_WAIT: begin
            if (window_evt_s) begin
               state_nxt_s = S_LOAD;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_LOAD: begin
            load_en_s   = 1'b1;
            state_nxt_s = S_PRESENT;
            if (window_evt_s) begin
               pend_nxt_s    = 1'b1;
               overrun_nxt_s = overrun_r | pend_r;
            end else begin
               pend_nxt_s = pend_r;
            end
         end
         S_PRESENT: begin
            if (win_ready) begin
               if (pend_r) begin
                  state_nxt_s   = S_LOAD;
                  pend_nxt_s    = 1'b0;
                  overrun_nxt_s = overrun_r | window_evt_s;
               end else if (window_evt_s) begin
                  state_nxt_s = S_LOAD;
               end else begin
                  state_nxt_s = S_WAIT;
               end
            end else if (window_evt_s) begin
               pend_nxt_s    = 1'b1;
               overrun_nxt_s = overrun_r | pend_r;
            end else begin
               pend_nxt_s = pend_r;
            end
         end
         default: begin
            state_nxt_s = S_WAIT;
            pend_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, pending flag, sticky overrun and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r      <= S_WAIT;
         pend_r       <= 1'b0;
         overrun_r    <= 1'b0;
         win_valid_r  <= 1'b0;
         win_top_r    <= '0;
         win_mid_r    <= '0;
         win_bot_r    <= '0;
         win_last_r   <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         pend_r       <= pend_nxt_s;
         overrun_r    <= overrun_nxt_s;
         win_valid_r  <= (state_nxt_s == S_PRESENT);
         frame_done_r <= accept_s && win_last_r;
         if (load_en_s) begin
            win_top_r  <= top_sel_s;
            win_mid_r  <= mid_sel_s;
            win_bot_r  <= bot_sel_s;
            win_last_r <= cap_last_r;
         end else begin
            win_top_r  <= win_top_r;
            win_mid_r  <= win_mid_r;
            win_bot_r  <= win_bot_r;
            win_last_r <= win_last_r;
         end
      end
   end

   assign win_valid  = win_valid_r;
   assign win_top    = win_top_r;
   assign win_mid    = win_mid_r;
   assign win_bot    = win_bot_r;
   assign win_last   = win_last_r;
   assign frame_done = frame_done_r;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_row_window_reader.sv
// ----------------------------------------------------------------------------
// tb_row_window_reader
//   Acts as the row bank (writes slot data one clock after the control code),
//   drives directed and random traffic, and compares every cycle against a
//   transaction-level model built from row history and window records.
// ----------------------------------------------------------------------------
module tb_row_window_reader;

   localparam int RW = 32;
   localparam int IR = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic [2:0]    control;
   logic [RW-1:0] row_addr_1, row_addr_2, row_addr_3, row_addr_4;
   logic          win_valid, win_ready;
   logic [RW-1:0] win_top, win_mid, win_bot;
   logic          win_last, frame_done, overrun;

   row_window_reader #(.ROW_W(RW), .IMG_ROWS(IR)) dut (
      .clock      (clock),
      .reset      (reset),
      .control    (control),
      .row_addr_1 (row_addr_1),
      .row_addr_2 (row_addr_2),
      .row_addr_3 (row_addr_3),
      .row_addr_4 (row_addr_4),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_top    (win_top),
      .win_mid    (win_mid),
      .win_bot    (win_bot),
      .win_last   (win_last),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clock = ~clock;

   // Row bank stand-in: slot contents change one clock after the write code
   logic [RW-1:0] bank [1:4];
   logic [RW-1:0] wr_data;
   always @(posedge clock) begin
      if (control >= 3'd1 && control <= 3'd4) bank[control] <= wr_data;
   end
   assign row_addr_1 = bank[1];
   assign row_addr_2 = bank[2];
   assign row_addr_3 = bank[3];
   assign row_addr_4 = bank[4];

   // Window record: the three slots (oldest..newest) plus the last-row flag
   typedef struct { bit v; int s0; int s1; int s2; bit last; } rec_t;
   typedef struct { bit v; logic [RW-1:0] t; logic [RW-1:0] m; logic [RW-1:0] b; bit last; } shown_t;

   rec_t   hold;      // window waiting behind the presented one
   rec_t   load;      // window being fetched from the bank this cycle
   shown_t shown;     // window on the outputs
   bit     m_done, m_ovr;
   int     frame_n;   // rows seen in the current frame
   int     hist[$];   // last three slots written
   int     last_slot; // slot the bench wrote last (0 after reset)

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge
   task automatic tick(input logic [2:0] ctrl, input bit rdy, input bit rst, input logic [RW-1:0] data);
      rec_t   nh, nl, nw;
      shown_t ns;
      bit     nd, win, acc;
      control   = ctrl;
      win_ready = rdy;
      reset     = rst;
      wr_data   = data;
      nh = '{default:0};
      nl = '{default:0};
      nw = '{default:0};
      ns = '{default:0};
      nd = 1'b0;
      if (rst) begin
         m_ovr     = 1'b0;
         frame_n   = 0;
         last_slot = 0;
         hist.delete();
      end else begin
         win = 1'b0;
         if (ctrl >= 3'd1 && ctrl <= 3'd4) begin
            hist.push_back(int'(ctrl));
            if (hist.size() > 3) void'(hist.pop_front());
            frame_n++;
            if (frame_n >= 3) begin
               win     = 1'b1;
               nw.v    = 1'b1;
               nw.s0   = hist[0];
               nw.s1   = hist[1];
               nw.s2   = hist[2];
               nw.last = (frame_n == IR);
            end
            if (frame_n == IR) frame_n = 0;
         end
         acc = shown.v && rdy;
         nd  = acc && shown.last;
         ns  = shown;
         if (load.v) begin
            ns.v    = 1'b1;
            ns.t    = bank[load.s0];
            ns.m    = bank[load.s1];
            ns.b    = bank[load.s2];
            ns.last = load.last;
         end else if (acc) begin
            ns.v = 1'b0;
         end
         nh = hold;
         if (!load.v && (!shown.v || acc)) begin
            if (win) begin
               nl = nw;
               if (hold.v) m_ovr = 1'b1;
               nh.v = 1'b0;
            end else if (hold.v) begin
               nl   = hold;
               nh.v = 1'b0;
            end
         end else if (win) begin
            if (hold.v) m_ovr = 1'b1;
            nh = nw;
         end
      end
      @(posedge clock);
      #1;
      hold   = nh;
      load   = nl;
      shown  = ns;
      m_done = nd;
      check("win_valid", RW'(win_valid), RW'(shown.v));
      if (shown.v) begin
         check("win_top", win_top, shown.t);
         check("win_mid", win_mid, shown.m);
         check("win_bot", win_bot, shown.b);
         check("win_last", RW'(win_last), RW'(shown.last));
      end
      check("frame_done", RW'(frame_done), RW'(m_done));
      check("overrun", RW'(overrun), RW'(m_ovr));
   endtask

   task automatic wr(input logic [RW-1:0] data, input bit rdy);
      last_slot = last_slot % 4 + 1;
      tick(3'(last_slot), rdy, 1'b0, data);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) tick(3'd0, rdy, 1'b0, RW'($urandom));
   endtask

   logic [2:0] junk_codes [4];

   initial begin
      junk_codes[0] = 3'd0;
      junk_codes[1] = 3'd5;
      junk_codes[2] = 3'd6;
      junk_codes[3] = 3'd7;
      for (int k = 1; k <= 4; k++) bank[k] = '0;
      hold = '{default:0};
      load = '{default:0};
      shown = '{default:0};
      m_done = 1'b0;
      m_ovr = 1'b0;
      frame_n = 0;
      last_slot = 0;
      control = 3'd0;
      win_ready = 1'b0;
      reset = 1'b1;
      wr_data = '0;

      tick(3'd0, 1'b0, 1'b1, '0);
      tick(3'd0, 1'b0, 1'b1, '0);
      check("rst_top", win_top, '0);
      check("rst_last", RW'(win_last), '0);

      // Rows A,B,C: window appears two cycles after the third write
      wr(32'hA000_000A, 1'b1);
      wr(32'hB000_000B, 1'b1);
      wr(32'hC000_000C, 1'b1);
      check("lat_n1", RW'(win_valid), '0);
      idle(1, 1'b1);
      check("lat_n2", RW'(win_valid), RW'(1'b1));
      check("abc_top", win_top, 32'hA000_000A);
      check("abc_mid", win_mid, 32'hB000_000B);
      check("abc_bot", win_bot, 32'hC000_000C);
      idle(2, 1'b1);

      // D into slot 4, E wraps into slot 1 and is the frame's last row
      wr(32'hD000_000D, 1'b1);
      idle(3, 1'b1);
      wr(32'hE000_000E, 1'b0);
      idle(2, 1'b0);
      check("wrap_top", win_top, 32'hC000_000C);
      check("wrap_bot", win_bot, 32'hE000_000E);
      check("wrap_last", RW'(win_last), RW'(1'b1));
      idle(1, 1'b1);
      check("frame_done", RW'(frame_done), RW'(1'b1));

      // Next frame: two rows give no window, the third does
      wr($urandom, 1'b1);
      wr($urandom, 1'b1);
      idle(3, 1'b1);
      wr($urandom, 1'b1);
      idle(3, 1'b1);

      // Pend then overrun with a stalled consumer, cleared by reset
      tick(3'd0, 1'b0, 1'b1, '0);
      wr(32'h1111_0001, 1'b0);
      wr(32'h2222_0002, 1'b0);
      wr(32'h3333_0003, 1'b0);
      idle(3, 1'b0);
      wr(32'h4444_0004, 1'b0);
      idle(2, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);
      check("pend_bot", win_bot, 32'h4444_0004);
      wr(32'h5555_0005, 1'b0);
      wr($urandom, 1'b0);
      wr($urandom, 1'b0);
      wr($urandom, 1'b0);
      idle(1, 1'b0);
      check("ovr_set", RW'(overrun), RW'(1'b1));
      tick(3'd0, 1'b0, 1'b1, '0);
      check("rst_drop", RW'(win_valid), '0);
      check("rst_ovr", RW'(overrun), '0);
      wr($urandom, 1'b1);
      wr($urandom, 1'b1);
      idle(3, 1'b1);
      wr($urandom, 1'b1);
      idle(4, 1'b1);

      // Non-write codes change nothing
      for (int i = 0; i < 40; i++)
         tick(junk_codes[$urandom_range(0, 3)], 1'($urandom), 1'b0, RW'($urandom));
      check("junk_idle", RW'(win_valid), '0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            tick(3'd0, 1'b0, 1'b1, '0);
         end else if ($urandom_range(0, 9) < 4) begin
            wr(RW'($urandom), ($urandom_range(0, 9) < 7));
         end else begin
            tick(junk_codes[$urandom_range(0, 3)], ($urandom_range(0, 9) < 7), 1'b0, RW'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
